// File: rtl/rsa_ctrl_pkg.sv
// Shared types and defaults for the RSA start/done handshake controller.
package rsa_ctrl_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int WD_W               = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_REPORT    = 3'd4
    } state_t;

endpackage

// File: rtl/rsa_ctrl_watchdog.sv
// Cycle watchdog for the controller wait states; used only when
// RSA_START_CTRL_TIMEOUT_EN is defined.
module rsa_ctrl_watchdog
    import rsa_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count holds the cycles already spent in the state, so the state's
    // TIMEOUT_CYCLES-th cycle is the one that sees expired.
    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/rsa_start_ctrl.sv
// Start/done handshake controller for the RSA engine. Define
// RSA_START_CTRL_TIMEOUT_EN to add the wait-state watchdog abort path.
module rsa_start_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    output logic             start,
    input  logic             finished,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_timeout,
    output logic [CNT_W-1:0] job_count
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("rsa_start_ctrl: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t state;
    state_t state_next;
    logic   wd_expired;
    logic   success;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A finished rise beats a same-cycle watchdog expiry.
    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:      if (job_valid && finished) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!finished) state_next = ST_WAIT_DONE;
                          else if (wd_expired) state_next = ST_REPORT;
            ST_WAIT_DONE: if (finished || wd_expired) state_next = ST_REPORT;
            ST_REPORT:    if (done_ready) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        job_ready  = (state == ST_IDLE) && finished;
        start      = (state == ST_START);
        done_valid = (state == ST_REPORT);
    end

    assign success = (state == ST_WAIT_DONE) && finished;

    always_ff @(posedge clk) begin
        if (rst) begin
            job_count <= '0;
        end else if (success) begin
            job_count <= job_count + 1'b1;
        end
    end

`ifdef RSA_START_CTRL_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;
    logic timeout_q;

    // Restart the count on every state change so each wait state gets a full budget.
    assign wd_clear  = (state != state_next);
    assign wd_enable = (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);

    rsa_ctrl_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Captured on entry to REPORT and held until the host handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (wd_enable && (state_next == ST_REPORT)) begin
            timeout_q <= !success;
        end
    end

    assign done_timeout = done_valid && timeout_q;
`else
    assign wd_expired   = 1'b0;
    assign done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_start_ctrl.sv
// Directed self-checking bench for rsa_start_ctrl; the timeout scenario runs
// when RSA_START_CTRL_TIMEOUT_EN is defined for the build.
module tb_rsa_start_ctrl;

    localparam int CNT_W = 4;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic             start;
    logic             finished;
    logic             done_valid;
    logic             done_ready;
    logic             done_timeout;
    logic [CNT_W-1:0] job_count;

    int checks   = 0;
    int failures = 0;

    rsa_start_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .start        (start),
        .finished     (finished),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_timeout (done_timeout),
        .job_count    (job_count)
    );

    always #5 clk = ~clk;

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; job_valid = 1'b0; finished = 1'b1; done_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Minimal-latency job from IDLE with finished=1, ending back in IDLE.
    task automatic run_job(input logic [CNT_W-1:0] exp_count);
        job_valid = 1'b1; finished = 1'b1;
        smp();
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL job_accept job_ready=%b exp=1", job_ready); end
        tick();
        job_valid = 1'b0;
        smp();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL job_start start=%b exp=1", start); end
        tick();
        finished = 1'b0;
        tick();
        finished = 1'b1;
        tick();
        smp();
        checks++; if ({done_valid, done_timeout} !== 2'b10) begin failures++; $display("FAIL job_report valid,timeout=%b exp=10", {done_valid, done_timeout}); end
        checks++; if (job_count !== exp_count) begin failures++; $display("FAIL job_count got=%0d exp=%0d", job_count, exp_count); end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        smp();
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL job_handshake done_valid=%b exp=0", done_valid); end
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        smp();
        checks++; if ({start, done_valid, done_timeout} !== 3'b000) begin failures++; $display("FAIL reset_outputs start,valid,timeout=%b exp=000", {start, done_valid, done_timeout}); end
        checks++; if (job_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", job_count); end
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL reset_idle job_ready=%b exp=1", job_ready); end
        tick();
        rst = 1'b0;
    endtask

    // Cycle-accurate latency run; done_ready is held high outside REPORT and must be ignored.
    task automatic test_basic();
        job_valid = 1'b1; finished = 1'b1;
        smp();
        checks++; if ({job_ready, start} !== 2'b10) begin failures++; $display("FAIL basic_c0 ready,start=%b exp=10", {job_ready, start}); end
        tick();
        job_valid = 1'b0;
        smp();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL basic_c1 start=%b exp=1", start); end
        tick();
        finished = 1'b0; done_ready = 1'b1;
        smp();
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL basic_c2 start=%b exp=0", start); end
        tick();
        for (int c = 3; c < 10; c++) begin
            smp();
            checks++; if ({start, done_valid} !== 2'b00) begin failures++; $display("FAIL basic_wait c=%0d start,valid=%b exp=00", c, {start, done_valid}); end
            tick();
        end
        finished = 1'b1;
        smp();
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL basic_c10 done_valid=%b exp=0", done_valid); end
        tick();
        smp();
        checks++; if ({done_valid, done_timeout} !== 2'b10) begin failures++; $display("FAIL basic_c11 valid,timeout=%b exp=10", {done_valid, done_timeout}); end
        checks++; if (job_count !== 4'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", job_count); end
        tick();
        done_ready = 1'b0;
        smp();
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL basic_c12 done_valid=%b exp=0", done_valid); end
        tick();
    endtask

    // Engine busy on request, then a result held back by the host.
    task automatic test_busy_hold();
        job_valid = 1'b1; finished = 1'b0;
        for (int c = 0; c < 20; c++) begin
            smp();
            checks++; if ({job_ready, start} !== 2'b00) begin failures++; $display("FAIL busy_hold c=%0d ready,start=%b exp=00", c, {job_ready, start}); end
            tick();
        end
        finished = 1'b1;
        smp();
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL busy_accept job_ready=%b exp=1", job_ready); end
        tick();
        smp();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL busy_start start=%b exp=1", start); end
        tick();
        finished = 1'b0;
        tick();
        finished = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            smp();
            checks++; if ({done_valid, done_timeout, job_ready} !== 3'b100) begin failures++; $display("FAIL report_stall c=%0d valid,timeout,ready=%b exp=100", c, {done_valid, done_timeout, job_ready}); end
            tick();
        end
        done_ready = 1'b1;
        smp();
        checks++; if ({done_valid, job_ready} !== 2'b10) begin failures++; $display("FAIL report_hs valid,ready=%b exp=10", {done_valid, job_ready}); end
        checks++; if (job_count !== 4'd2) begin failures++; $display("FAIL busy_count got=%0d exp=2", job_count); end
        tick();
        done_ready = 1'b0;
        smp();
        checks++; if ({done_valid, job_ready} !== 2'b01) begin failures++; $display("FAIL second_accept valid,ready=%b exp=01", {done_valid, job_ready}); end
        tick();
        job_valid = 1'b0;
        smp();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL second_start start=%b exp=1", start); end
        tick();
        finished = 1'b0;
        tick();
        finished = 1'b1;
        tick();
        smp();
        checks++; if ({done_valid, job_count} !== {1'b1, 4'd3}) begin failures++; $display("FAIL second_done valid=%b count=%0d exp valid=1 count=3", done_valid, job_count); end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        job_valid = 1'b1; finished = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        finished = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; finished = 1'b1;
        smp();
        checks++; if ({start, done_valid, job_ready} !== 3'b001) begin failures++; $display("FAIL rst_wait_idle start,valid,ready=%b exp=001", {start, done_valid, job_ready}); end
        checks++; if (job_count !== '0) begin failures++; $display("FAIL rst_wait_count got=%0d exp=0", job_count); end
        tick();
        for (int c = 0; c < 3; c++) begin
            smp();
            checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL rst_no_done c=%0d done_valid=%b exp=0", c, done_valid); end
            tick();
        end
        run_job(4'd1);
        job_valid = 1'b1;
        tick();
        smp();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_start_pre start=%b exp=1", start); end
        rst = 1'b1; job_valid = 1'b0;
        tick();
        smp();
        checks++; if ({start, job_count} !== {1'b0, 4'd0}) begin failures++; $display("FAIL rst_start_drop start=%b count=%0d exp start=0 count=0", start, job_count); end
        rst = 1'b0;
        tick();
        run_job(4'd1);
    endtask

    task automatic test_back_to_back_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            run_job(CNT_W'(i + 1));
        end
        smp();
        checks++; if (job_count !== 4'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", job_count); end
        tick();
    endtask

`ifdef RSA_START_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        job_valid = 1'b1; finished = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        for (int c = 0; c < TO; c++) begin
            smp();
            checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL to_early c=%0d done_valid=%b exp=0", c, done_valid); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            smp();
            checks++; if ({done_valid, done_timeout, job_count} !== {2'b11, 4'd0}) begin failures++; $display("FAIL to_report c=%0d valid,timeout=%b count=%0d exp 11 count 0", c, {done_valid, done_timeout}, job_count); end
            if (c == 2) done_ready = 1'b1;
            tick();
        end
        done_ready = 1'b0;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        finished = 1'b0;
        tick();
        for (int c = 0; c < TO - 1; c++) begin
            smp();
            checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL race_early c=%0d done_valid=%b exp=0", c, done_valid); end
            tick();
        end
        finished = 1'b1;
        tick();
        smp();
        checks++; if ({done_valid, done_timeout, job_count} !== {2'b10, 4'd1}) begin failures++; $display("FAIL race_success valid,timeout=%b count=%0d exp 10 count 1", {done_valid, done_timeout}, job_count); end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_time_limit reached exp=finish earlier");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; job_valid = 1'b0; finished = 1'b1; done_ready = 1'b0;
        test_reset();
        test_basic();
        test_busy_hold();
        test_reset_mid();
        test_back_to_back_wrap();
`ifdef RSA_START_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
